acq_sequencer: RTL and testbench

- Master acquisition sequencer for the I/Q ADC front end and the AGC DAC.
- On a start command it:
  - loads the AGC level through the AGC SPI writer;
  - waits for the analog path to settle;
  - loads both ADC interface control words;
  - enables both ADC interfaces for a programmed number of samples.
- Supports single-shot and continuous framing, with abort.
- Drives the agc_data/agc_load and adc_*_ctrlword/ldctrl/enable nets of the top level.

---
 rtl/acq_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_acq_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// acq_sequencer: AGC load -> settle -> ADC config -> framed capture. The capture watchdog is built only with ACQ_SEQ_TIMEOUT_EN.
// Latency: agc_load 1 cycle after start, adc_ldctrl AGC_SETTLE_CYC later, adc_enable CFG_WAIT_CYC after that.
// Backpressure: none; start is dropped silently while busy, and stop aborts from any active state.
module acq_sequencer #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned AGC_SETTLE_CYC = 48000,
  parameter int unsigned CFG_WAIT_CYC   = 100,
  parameter int unsigned TIMEOUT_CYC    = 65536
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [15:0]      agc_word,
  input  logic [9:0]       ctrl_word,
  input  logic [CNT_W-1:0] nsamples,
  input  logic             sample_valid,
  output logic [15:0]      agc_data,
  output logic             agc_load,
  output logic [9:0]       adc_ctrlword,
  output logic             adc_ldctrl,
  output logic             adc_enable,
  output logic             busy,
  output logic             frame_done,
  output logic             aborted,
  output logic             cmd_err,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AGC_LOAD,
    ST_AGC_SETTLE,
    ST_ADC_CFG,
    ST_CFG_WAIT,
    ST_CAPTURE
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(AGC_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CFGW_LAST   = CNT_W'(CFG_WAIT_CYC - 1);

  state_t           state_q;
  logic [15:0]      agc_data_q;
  logic [9:0]       adc_ctrlword_q;
  logic [9:0]       ctrl_q;
  logic [CNT_W-1:0] nsamples_q;
  logic             cont_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic             agc_load_q;
  logic             adc_ldctrl_q;
  logic             adc_enable_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             aborted_q;
  logic             cmd_err_q;

  logic [CNT_W-1:0] cyc_d;
  logic [CNT_W-1:0] sample_cnt_d;
  logic             settle_done;
  logic             cfg_done;
  logic             frame_last;
  logic             wd_expired;

  assign cyc_d        = cyc_q + CNT_W'(1);
  assign sample_cnt_d = sample_cnt_q + CNT_W'(1);
  // Interval counts start on the pulse cycle itself, so the pulse cycle is count 0.
  assign settle_done  = (cyc_q == SETTLE_LAST);
  assign cfg_done     = (cyc_q == CFGW_LAST);
  assign frame_last   = (sample_cnt_q == (nsamples_q - CNT_W'(1)));

`ifdef ACQ_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wd_q <= '0;
    end else if (state_q != ST_CAPTURE || sample_valid) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + CNT_W'(1);
    end
  end

  assign wd_expired = (state_q == ST_CAPTURE) && !sample_valid && (wd_q == WD_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q        <= ST_IDLE;
      agc_data_q     <= 16'h2AAA;
      adc_ctrlword_q <= 10'b0000100100;
      ctrl_q         <= 10'b0000100100;
      nsamples_q     <= '0;
      cont_q         <= 1'b0;
      cyc_q          <= '0;
      sample_cnt_q   <= '0;
      agc_load_q     <= 1'b0;
      adc_ldctrl_q   <= 1'b0;
      adc_enable_q   <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      aborted_q      <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      agc_load_q   <= 1'b0;
      adc_ldctrl_q <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      if (state_q != ST_IDLE && stop) begin
        // Abort outranks a frame completing on the same cycle; sample_cnt keeps its value.
        state_q      <= ST_IDLE;
        adc_enable_q <= 1'b0;
        busy_q       <= 1'b0;
        aborted_q    <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !stop) begin
              if (nsamples != '0) begin
                nsamples_q   <= nsamples;
                cont_q       <= continuous;
                ctrl_q       <= ctrl_word;
                agc_data_q   <= agc_word;
                agc_load_q   <= 1'b1;
                busy_q       <= 1'b1;
                cyc_q        <= '0;
                sample_cnt_q <= '0;
                state_q      <= ST_AGC_LOAD;
              end else begin
                cmd_err_q <= 1'b1;
              end
            end
          end
          ST_AGC_LOAD, ST_AGC_SETTLE: begin
            if (settle_done) begin
              adc_ctrlword_q <= ctrl_q;
              adc_ldctrl_q   <= 1'b1;
              cyc_q          <= '0;
              state_q        <= ST_ADC_CFG;
            end else begin
              cyc_q   <= cyc_d;
              state_q <= ST_AGC_SETTLE;
            end
          end
          ST_ADC_CFG, ST_CFG_WAIT: begin
            if (cfg_done) begin
              adc_enable_q <= 1'b1;
              sample_cnt_q <= '0;
              state_q      <= ST_CAPTURE;
            end else begin
              cyc_q   <= cyc_d;
              state_q <= ST_CFG_WAIT;
            end
          end
          ST_CAPTURE: begin
            if (wd_expired) begin
              cmd_err_q    <= 1'b1;
              adc_enable_q <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end else if (sample_valid) begin
              if (frame_last) begin
                sample_cnt_q <= '0;
                frame_done_q <= 1'b1;
                if (!cont_q) begin
                  adc_enable_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
                end
              end else begin
                sample_cnt_q <= sample_cnt_d;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign agc_data     = agc_data_q;
  assign agc_load     = agc_load_q;
  assign adc_ctrlword = adc_ctrlword_q;
  assign adc_ldctrl   = adc_ldctrl_q;
  assign adc_enable   = adc_enable_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign aborted      = aborted_q;
  assign cmd_err      = cmd_err_q;
  assign sample_cnt   = sample_cnt_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboarded bench for acq_sequencer: the stimulus side pushes expected output events, and a negedge monitor pops and compares them.
module tb_acq_sequencer;
  localparam int CNT_W = 32;
  localparam int S     = 10;
  localparam int C     = 5;
  localparam int T     = 20;

  // Event kinds, listed in the order the monitor scans them within one cycle.
  localparam int EV_AGC = 0, EV_LD = 1, EV_ENR = 2, EV_FD = 3, EV_ENF = 4, EV_AB = 5, EV_ERR = 6;

  logic             clk = 1'b0;
  logic             arstn = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             continuous = 1'b0;
  logic [15:0]      agc_word = '0;
  logic [9:0]       ctrl_word = '0;
  logic [CNT_W-1:0] nsamples = '0;
  logic             sample_valid = 1'b0;
  logic [15:0]      agc_data;
  logic             agc_load;
  logic [9:0]       adc_ctrlword;
  logic             adc_ldctrl;
  logic             adc_enable;
  logic             busy;
  logic             frame_done;
  logic             aborted;
  logic             cmd_err;
  logic [CNT_W-1:0] sample_cnt;

  acq_sequencer #(
    .CNT_W(CNT_W), .AGC_SETTLE_CYC(S), .CFG_WAIT_CYC(C), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .arstn(arstn), .start(start), .stop(stop), .continuous(continuous),
    .agc_word(agc_word), .ctrl_word(ctrl_word), .nsamples(nsamples),
    .sample_valid(sample_valid), .agc_data(agc_data), .agc_load(agc_load),
    .adc_ctrlword(adc_ctrlword), .adc_ldctrl(adc_ldctrl), .adc_enable(adc_enable),
    .busy(busy), .frame_done(frame_done), .aborted(aborted), .cmd_err(cmd_err),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] dat);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [31:0] dat);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d cyc=%0d dat=%h required none", kind, cyc, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.dat !== dat) begin
        failures++;
        $display("FAIL event actual kind=%0d cyc=%0d dat=%h required kind=%0d cyc=%0d dat=%h",
                 kind, cyc, dat, e.kind, e.cyc, e.dat);
      end
    end
  endtask

  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (!arstn) begin
      prev_en = 1'b0;
    end else begin
      if (agc_load) observe(EV_AGC, 32'(agc_data));
      if (adc_ldctrl) observe(EV_LD, 32'(adc_ctrlword));
      if (adc_enable && !prev_en) observe(EV_ENR, 32'd0);
      if (frame_done) observe(EV_FD, sample_cnt);
      if (!adc_enable && prev_en) observe(EV_ENF, 32'd0);
      if (aborted) observe(EV_AB, sample_cnt);
      if (cmd_err) observe(EV_ERR, 32'd0);
      prev_en = adc_enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      tick();
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_agc_data"}, 32'(agc_data), 32'h2AAA);
    chk({tag, "_ctrlword"}, 32'(adc_ctrlword), 32'h024);
    chk({tag, "_outs"}, {25'd0, agc_load, adc_ldctrl, adc_enable, busy, frame_done, aborted, cmd_err}, 32'd0);
    chk({tag, "_sample_cnt"}, sample_cnt, 32'd0);
  endtask

  // One command: optional early stop at t0+early, or nstr strobes with optional stop on strobe stop_k.
  task automatic run_seq(input logic [15:0] agc, input logic [9:0] ctrl, input int n, input bit cont,
                         input int nstr, input int stop_k, input int early, input int gmin, input int gmax);
    int t0, ten, k, t;
    bit ended, stopped;
    ended = 1'b0;
    stopped = 1'b0;
    k = 0;
    agc_word = agc;
    ctrl_word = ctrl;
    nsamples = CNT_W'(n);
    continuous = cont;
    start = 1'b1;
    t0 = cyc;
    ten = t0 + 1 + S + C;
    push(EV_AGC, t0 + 1, 32'(agc));
    if (early == 0 || early >= 1 + S) push(EV_LD, t0 + 1 + S, 32'(ctrl));
    if (early == 0) push(EV_ENR, ten, 32'd0);
    else push(EV_AB, t0 + early + 1, 32'd0);
    tick();
    while (cyc < ten) begin
      if (early != 0 && cyc == t0 + early) begin
        start = 1'b0;
        sample_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain();
        chk("busy_after_early_stop", 32'(busy), 32'd0);
        return;
      end
      // Ignored traffic while the sequence is in its configuration phase.
      start = ($urandom_range(0, 3) == 0);
      sample_valid = 1'($urandom_range(0, 1));
      continuous = 1'($urandom_range(0, 1));
      nsamples = CNT_W'($urandom_range(0, 2));
      agc_word = 16'($urandom);
      ctrl_word = 10'($urandom);
      tick();
    end
    start = 1'b0;
    sample_valid = 1'b0;
    chk("busy_capture", 32'(busy), 32'd1);
    while (k < nstr) begin
      repeat ($urandom_range(gmin, gmax)) tick();
      sample_valid = 1'b1;
      k++;
      t = cyc;
      if (!ended) begin
        if (stop_k == k) begin
          stop = 1'b1;
          stopped = 1'b1;
          push(EV_ENF, t + 1, 32'd0);
          push(EV_AB, t + 1, 32'((k - 1) % n));
        end else if (k % n == 0) begin
          push(EV_FD, t + 1, 32'd0);
          if (!cont) begin
            push(EV_ENF, t + 1, 32'd0);
            ended = 1'b1;
          end
        end
      end
      tick();
      sample_valid = 1'b0;
      stop = 1'b0;
      if (stopped) break;
    end
    if (!ended && !stopped) begin
      tick();
      tick();
      stop = 1'b1;
      push(EV_ENF, cyc + 1, 32'd0);
      push(EV_AB, cyc + 1, 32'(k % n));
      tick();
      stop = 1'b0;
    end
    drain();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("enable_idle", 32'(adc_enable), 32'd0);
  endtask

  task automatic silence_test();
    int t0, ten;
    agc_word = 16'h0F0F;
    ctrl_word = 10'h155;
    nsamples = CNT_W'(5);
    continuous = 1'b0;
    start = 1'b1;
    t0 = cyc;
    ten = t0 + 1 + S + C;
    push(EV_AGC, t0 + 1, 32'h0F0F);
    push(EV_LD, t0 + 1 + S, 32'h155);
    push(EV_ENR, ten, 32'd0);
    tick();
    start = 1'b0;
    while (cyc < ten) tick();
`ifdef ACQ_SEQ_TIMEOUT_EN
    push(EV_ENF, ten + T, 32'd0);
    push(EV_ERR, ten + T, 32'd0);
    drain();
    chk("timeout_busy", 32'(busy), 32'd0);
`else
    repeat (3 * T) tick();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_enable", 32'(adc_enable), 32'd1);
    stop = 1'b1;
    push(EV_ENF, cyc + 1, 32'd0);
    push(EV_AB, cyc + 1, 32'd0);
    tick();
    stop = 1'b0;
    drain();
`endif
  endtask

  task automatic reset_test();
    int t0, ten;
    agc_word = 16'hBEEF;
    ctrl_word = 10'h3C3;
    nsamples = CNT_W'(5);
    continuous = 1'b0;
    start = 1'b1;
    t0 = cyc;
    ten = t0 + 1 + S + C;
    push(EV_AGC, t0 + 1, 32'hBEEF);
    push(EV_LD, t0 + 1 + S, 32'h3C3);
    push(EV_ENR, ten, 32'd0);
    tick();
    start = 1'b0;
    while (cyc < ten) tick();
    sample_valid = 1'b1;
    tick();
    tick();
    sample_valid = 1'b0;
    chk("pre_reset_sample_cnt", sample_cnt, 32'd2);
    #2;
    arstn = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("midreset");
    tick();
    tick();
    arstn = 1'b1;
    tick();
    chk_reset_vals("post_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tick();
    tick();
    chk_reset_vals("in_reset");
    arstn = 1'b1;
    repeat (30) tick();
    chk_reset_vals("idle");

    run_seq(16'h1234, 10'h024, 4, 1'b0, 4, 0, 0, 2, 2);
    run_seq(16'h5A5A, 10'h2F1, 3, 1'b1, 9, 0, 0, 0, 4);
    run_seq(16'h00FF, 10'h111, 4, 1'b0, 4, 4, 0, 0, 3);
    run_seq(16'h8001, 10'h3FF, 1, 1'b1, 4, 0, 0, 0, 2);

    nsamples = '0;
    start = 1'b1;
    push(EV_ERR, cyc + 1, 32'd0);
    tick();
    start = 1'b0;
    tick();
    chk("cmd_err_busy", 32'(busy), 32'd0);
    drain();

    nsamples = CNT_W'(3);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    chk("start_stop_busy", 32'(busy), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain();

    reset_test();
    run_seq(16'h4321, 10'h0AA, 2, 1'b0, 2, 0, 0, 0, 3);
    silence_test();

    for (int i = 0; i < 25; i++) begin
      int n, nstr, sk, ea;
      bit cont;
      n = $urandom_range(1, 5);
      cont = 1'($urandom_range(0, 1));
      nstr = $urandom_range(1, 2 * n + 1);
      sk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nstr) : 0;
      ea = ($urandom_range(0, 4) == 0) ? $urandom_range(1, S + C) : 0;
      run_seq(16'($urandom), 10'($urandom), n, cont, nstr, sk, ea, 0, 5);
      repeat ($urandom_range(0, 3)) tick();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
